// File: rtl/gray_pkg.sv
// ----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-count monitor slice:
//   GMAX         widest Gray/binary bus the helpers accept
//   mon_state_t  monitor start-up / run sequencing states
//   gray2bin()   Gray -> binary decode of a zero-extended Gray word
//   popcount()   number of set bits in a zero-extended word
// Callers zero-extend their WIDTH-bit value to GMAX bits and truncate the
// result back, so one function body serves every instance width.
// ----------------------------------------------------------------------------
package gray_pkg;

  localparam int GMAX = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } mon_state_t;

  // Binary bit i is the XOR of Gray bits i..MSB. Bits above the caller's
  // width are zero, so they leave the low bits untouched.
  function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g);
    logic [GMAX-1:0] b;
    b[GMAX-1] = g[GMAX-1];
    for (int i = GMAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GMAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GMAX; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// ----------------------------------------------------------------------------
// gray_sync
// Multi-flop synchronizer for a Gray-coded bus arriving from another clock
// domain. Because only one bit of a legal Gray sequence changes at a time,
// each bit may be synchronized independently.
// Ports:
//   clk       sampling clock (rising edge)
//   rst       asynchronous active-low reset; clears every stage to 0
//   gray_in   asynchronous Gray bus (the only consumer of this input)
//   sync_out  last stage of the chain, safe to use in the clk domain
// ----------------------------------------------------------------------------
module gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_monitor.sv
// ----------------------------------------------------------------------------
// gray_count_monitor
// Consumer stage for a free-running Gray counter. Synchronizes the Gray bus,
// decodes it to binary, reports each forward advance as a step, accumulates
// the steps into a running total and flags wrap-around and illegal
// multi-bit Gray transitions.
// Parameters:
//   WIDTH        Gray/binary width (>= 2)
//   SYNC_STAGES  synchronizer depth (>= 2)
//   ACC_WIDTH    total width (>= WIDTH)
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   gray_in        asynchronous Gray count
//   en             count enable; low still tracks position, reports nothing
//   clr            synchronous clear of total, overflow, multi_bit_err
//   bin_out        registered binary position
//   step_valid     one-cycle pulse when the counter advanced
//   step           advance amount, qualified by step_valid
//   wrap           one-cycle pulse when the advance crossed all-ones -> zero
//   total          sum of steps modulo 2^ACC_WIDTH
//   overflow       sticky carry out of total
//   multi_bit_err  sticky: synchronized Gray changed more than one bit
// ----------------------------------------------------------------------------
module gray_count_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 en,
  input  logic                 clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_valid,
  output logic [WIDTH-1:0]     step,
  output logic                 wrap,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 overflow,
  output logic                 multi_bit_err
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES - 1);

  mon_state_t        state;
  logic [FILL_W-1:0] fill_cnt;

  logic [WIDTH-1:0]  sync_out_p0;
  logic [WIDTH-1:0]  prev_gray;
  logic [WIDTH-1:0]  prev_bin;

  logic [WIDTH-1:0]  cur_bin_p0;
  logic [WIDTH-1:0]  diff_p0;
  logic              adv_p0;
  logic              wrap_p0;
  logic              err_p0;
  logic [ACC_WIDTH:0] acc_sum_p0;

  gray_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .sync_out (sync_out_p0)
  );

  // ---- p0: decode, difference and flag detection on the synchronized bus --
  // Every difference is treated as a forward advance modulo 2^WIDTH; a
  // backward move is indistinguishable from a large forward step.
  always_comb begin
    cur_bin_p0 = WIDTH'(gray2bin(GMAX'(sync_out_p0)));
    diff_p0    = cur_bin_p0 - prev_bin;
    adv_p0     = en && (diff_p0 != '0);
    wrap_p0    = cur_bin_p0 < prev_bin;
    err_p0     = popcount(GMAX'(sync_out_p0 ^ prev_gray)) > 1;
    acc_sum_p0 = {1'b0, total} + (ACC_WIDTH + 1)'(diff_p0);
  end

  // ---- sequencing: wait for the synchronizer to fill, prime, then run -----
  // While FILL counts, the chain still holds reset zeros, so nothing derived
  // from it may be compared against prev values yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state <= PRIME;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        PRIME:   state <= RUN;
        RUN:     state <= RUN;
        default: state <= FILL;
      endcase
    end
  end

  // ---- p1: position tracking (independent of en) --------------------------
  // PRIME seeds prev from the current code so the position present at start-up
  // is never reported as a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_gray <= '0;
      prev_bin  <= '0;
      bin_out   <= '0;
    end else if (state == PRIME || state == RUN) begin
      prev_gray <= sync_out_p0;
      prev_bin  <= cur_bin_p0;
      bin_out   <= cur_bin_p0;
    end
  end

  // ---- p1: step reporting pulses -------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_valid <= 1'b0;
      step       <= '0;
      wrap       <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      wrap       <= 1'b0;
      if (state == RUN && adv_p0) begin
        step_valid <= 1'b1;
        step       <= diff_p0;
        wrap       <= wrap_p0;
      end
    end
  end

  // ---- p1: accumulator and sticky flags ------------------------------------
  // clr is applied last so it wins over a same-cycle accumulate or flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total         <= '0;
      overflow      <= 1'b0;
      multi_bit_err <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (adv_p0) begin
          total <= acc_sum_p0[ACC_WIDTH-1:0];
          if (acc_sum_p0[ACC_WIDTH]) begin
            overflow <= 1'b1;
          end
        end
        if (err_p0) begin
          multi_bit_err <= 1'b1;
        end
      end
      if (clr) begin
        total         <= '0;
        overflow      <= 1'b0;
        multi_bit_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_count_monitor.sv
// ----------------------------------------------------------------------------
// tb_gray_count_monitor
// Directed bench for gray_count_monitor. Instance a uses the default widths;
// instance b has ACC_WIDTH=4 to reach the total carry-out quickly.
// ----------------------------------------------------------------------------
module tb_gray_count_monitor;

  logic        clk;
  logic        rst;
  logic [3:0]  ga, gb;
  logic        en_a, en_b, clr_a, clr_b;

  logic [3:0]  bin_a, step_a, bin_b, step_b;
  logic        sv_a, wrap_a, ovf_a, err_a;
  logic        sv_b, wrap_b, ovf_b, err_b;
  logic [15:0] total_a;
  logic [3:0]  total_b;

  int n_cmp = 0;
  int n_err = 0;

  gray_count_monitor #(.WIDTH(4), .SYNC_STAGES(2), .ACC_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .gray_in(ga), .en(en_a), .clr(clr_a),
    .bin_out(bin_a), .step_valid(sv_a), .step(step_a), .wrap(wrap_a),
    .total(total_a), .overflow(ovf_a), .multi_bit_err(err_a)
  );

  gray_count_monitor #(.WIDTH(4), .SYNC_STAGES(2), .ACC_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .gray_in(gb), .en(en_b), .clr(clr_b),
    .bin_out(bin_b), .step_valid(sv_b), .step(step_b), .wrap(wrap_b),
    .total(total_b), .overflow(ovf_b), .multi_bit_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // New code on instance a; returns when its result is visible (latency 3).
  task automatic drive_a(input int b);
    ga = b2g(b);
    tick(3);
  endtask

  task automatic drive_b(input int b);
    gb = b2g(b);
    tick(3);
  endtask

  initial begin
    rst = 1'b0; ga = '0; gb = '0;
    en_a = 1'b1; en_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    tick(3);
    chk("rst.bin_a",   32'(bin_a),   32'd0);
    chk("rst.sv_a",    32'(sv_a),    32'd0);
    chk("rst.total_a", 32'(total_a), 32'd0);
    chk("rst.err_a",   32'(err_a),   32'd0);
    chk("rst.ovf_b",   32'(ovf_b),   32'd0);

    rst = 1'b1;
    tick(4);
    chk("prime.sv_a",  32'(sv_a),  32'd0);
    chk("prime.bin_a", 32'(bin_a), 32'd0);

    // 0000 -> 0001 -> 0011 -> 0010
    drive_a(1);
    chk("s1.sv",    32'(sv_a),    32'd1);
    chk("s1.step",  32'(step_a),  32'd1);
    chk("s1.bin",   32'(bin_a),   32'd1);
    chk("s1.total", 32'(total_a), 32'd1);
    tick(1);
    chk("s1.pulse_end", 32'(sv_a), 32'd0);
    drive_a(2);
    chk("s2.sv",    32'(sv_a),    32'd1);
    chk("s2.step",  32'(step_a),  32'd1);
    chk("s2.bin",   32'(bin_a),   32'd2);
    tick(1);
    drive_a(3);
    chk("s3.sv",    32'(sv_a),    32'd1);
    chk("s3.bin",   32'(bin_a),   32'd3);
    chk("s3.total", 32'(total_a), 32'd3);
    chk("s3.err",   32'(err_a),   32'd0);
    tick(1);

    // Walk up to 15, then wrap to 0
    for (int b = 4; b <= 15; b++) begin
      drive_a(b);
      tick(1);
    end
    chk("w15.total", 32'(total_a), 32'd15);
    chk("w15.bin",   32'(bin_a),   32'd15);
    drive_a(0);
    chk("wrap.sv",    32'(sv_a),    32'd1);
    chk("wrap.step",  32'(step_a),  32'd1);
    chk("wrap.wrap",  32'(wrap_a),  32'd1);
    chk("wrap.total", 32'(total_a), 32'd16);
    tick(1);
    chk("wrap.pulse_end", 32'(wrap_a), 32'd0);

    // Skip: 0001 -> 0010 (bin 1 -> 3)
    drive_a(1);
    chk("sk1.total", 32'(total_a), 32'd17);
    tick(1);
    drive_a(3);
    chk("skip.step",  32'(step_a),  32'd2);
    chk("skip.err",   32'(err_a),   32'd1);
    chk("skip.total", 32'(total_a), 32'd19);
    chk("skip.wrap",  32'(wrap_a),  32'd0);
    tick(1);
    drive_a(4);
    chk("skip.err_sticky", 32'(err_a),   32'd1);
    chk("sk4.total",       32'(total_a), 32'd20);
    tick(1);

    // clr coinciding with a step
    ga = b2g(5);
    tick(2);
    clr_a = 1'b1;
    tick(1);
    chk("clr.sv",    32'(sv_a),    32'd1);
    chk("clr.step",  32'(step_a),  32'd1);
    chk("clr.total", 32'(total_a), 32'd0);
    chk("clr.err",   32'(err_a),   32'd0);
    chk("clr.ovf",   32'(ovf_a),   32'd0);
    clr_a = 1'b0;
    tick(1);
    chk("clr.hold", 32'(total_a), 32'd0);

    drive_a(6);
    tick(1);
    drive_a(7);
    chk("r7.total", 32'(total_a), 32'd2);
    chk("r7.sv",    32'(sv_a),    32'd1);

    // Reset mid-run: outputs clear between clock edges
    rst = 1'b0;
    #2;
    chk("mrst.bin",   32'(bin_a),   32'd0);
    chk("mrst.total", 32'(total_a), 32'd0);
    chk("mrst.sv",    32'(sv_a),    32'd0);
    chk("mrst.step",  32'(step_a),  32'd0);
    tick(2);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("mrst.no_step", 32'(sv_a), 32'd0);
    end
    chk("mrst.bin7",  32'(bin_a),   32'd7);
    chk("mrst.tot0",  32'(total_a), 32'd0);
    drive_a(8);
    chk("mrst.next_sv",    32'(sv_a),    32'd1);
    chk("mrst.next_step",  32'(step_a),  32'd1);
    chk("mrst.next_total", 32'(total_a), 32'd1);
    tick(1);

    // en low: position tracked, nothing reported
    en_a = 1'b0;
    for (int b = 9; b <= 11; b++) begin
      drive_a(b);
      chk("en0.sv",  32'(sv_a),  32'd0);
      chk("en0.bin", 32'(bin_a), 32'(b));
      tick(1);
    end
    chk("en0.total", 32'(total_a), 32'd1);
    en_a = 1'b1;
    drive_a(12);
    chk("en1.sv",    32'(sv_a),    32'd1);
    chk("en1.step",  32'(step_a),  32'd1);
    chk("en1.total", 32'(total_a), 32'd2);
    chk("en1.bin",   32'(bin_a),   32'd12);
    tick(1);

    // Overflow on the 4-bit accumulator
    for (int k = 1; k <= 15; k++) begin
      drive_b(k % 16);
      tick(1);
    end
    chk("ov15.total", 32'(total_b), 32'd15);
    chk("ov15.ovf",   32'(ovf_b),   32'd0);
    drive_b(0);
    tick(1);
    drive_b(1);
    chk("ov17.total", 32'(total_b), 32'd1);
    chk("ov17.ovf",   32'(ovf_b),   32'd1);
    tick(1);
    gb = b2g(2);
    tick(2);
    clr_b = 1'b1;
    tick(1);
    chk("ovclr.sv",    32'(sv_b),    32'd1);
    chk("ovclr.step",  32'(step_b),  32'd1);
    chk("ovclr.total", 32'(total_b), 32'd0);
    chk("ovclr.ovf",   32'(ovf_b),   32'd0);
    clr_b = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_count_monitor.md
# gray_count_monitor

Consumer stage for a free-running Gray-code counter. It samples a WIDTH-bit Gray bus, which may come from another clock domain, through a synchronizer and decodes it to binary. It then reports each forward advance as a step amount and accumulates the advances into a running event total. It also flags illegal multi-bit Gray transitions and counter wrap-around, for use by the status/statistics logic that sits behind any Gray counter in the design.

## Interface
- WIDTH, 4, Gray/binary counter width (≥2)
- SYNC_STAGES, 2, synchronizer depth (≥2)
- ACC_WIDTH, 16, width of accumulated total (≥WIDTH)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- gray_in  in  WIDTH  Gray count from upstream counter, treated as asynchronous
- en  in  1  count enable; low = track position, report nothing
- clr  in  1  synchronous clear of total and sticky flags
- bin_out  out  WIDTH  registered binary value of synchronized gray_in
- step_valid  out  1  one-cycle pulse: counter advanced since last sample
- step  out  WIDTH  advance amount, valid with step_valid
- wrap  out  1  one-cycle pulse: advance crossed all-ones→zero
- total  out  ACC_WIDTH  accumulated sum of steps, modulo 2^ACC_WIDTH
- overflow  out  1  sticky: total carried out of ACC_WIDTH
- multi_bit_err  out  1  sticky: synchronized gray changed >1 bit between consecutive samples

## Operation
- Reset (rst low, asynchronous): all synchronizer flops, prev registers, and outputs go to 0; FSM goes to FILL.
- FSM states:
  - FILL: count SYNC_STAGES cycles after reset release; no outputs change; then go to PRIME.
  - PRIME: load prev_gray/prev_bin from the synchronizer output; bin_out updated; no step, wrap, or error; then go to RUN.
  - RUN: permanent state until reset.
- RUN, each cycle:
  - Decode: cur_bin = Gray→binary(sync_out), where bit WIDTH-1 passes through and bit i = XOR of gray bits i..WIDTH-1. Register cur_bin into bin_out.
  - Step: diff = (cur_bin − prev_bin) mod 2^WIDTH.
  - If en=1 and diff≠0:
    - step_valid=1, step=diff.
    - wrap=1 when cur_bin < prev_bin.
    - total += zero-extended diff; overflow set on carry out.
  - Error: if popcount(sync_out XOR prev_gray) > 1, multi_bit_err is set, independent of en.
  - Update prev_gray/prev_bin every RUN cycle, independent of en.
  - If en=0: step_valid=0, wrap=0, total held; the position is still tracked.
- clr=1: total, overflow, and multi_bit_err are loaded with 0. clr beats any same-cycle accumulation or flag set. step_valid, step, and wrap are still reported that cycle.
- Backward motion cannot be distinguished from a large forward step. Any diff is interpreted as forward, modulo 2^WIDTH.

## Timing
- A gray_in change before edge N appears at sync_out after edge N+SYNC_STAGES-1. bin_out, step_valid, step, wrap, total, and flags update at edge N+SYNC_STAGES. Latency is SYNC_STAGES+1 edges.
- Pulse outputs last exactly one cycle per change. An upstream that holds its value produces no pulses.
- First reported step after reset: the first change after PRIME. The value present at PRIME is never reported as a step.
- Reset asserted mid-RUN: outputs clear immediately, without a clock edge. Nothing is reported from pre-reset prev values after release.
- Total wraps modulo 2^ACC_WIDTH. overflow stays set until clr or reset.

## Structure
- Package gray_pkg: function gray2bin(WIDTH), popcount helper, FSM state enum (FILL, PRIME, RUN).
- Sub-module gray_sync: SYNC_STAGES×WIDTH flop chain with asynchronous active-low reset to 0. It is the only logic that touches gray_in.
- All remaining logic (FSM, decode, diff, accumulator, flags) lives in gray_count_monitor.

## Test plan
- Reset, then gray_in 0000→0001→0011→0010, one code every 4 cycles:
  - step_valid three times, each with step=1.
  - bin_out 1, 2, 3; total=3; multi_bit_err=0.
- Wrap: walk to 1000 (bin 15), then 0000:
  - final change gives step=1, wrap=1 for one cycle.
  - total continues incrementing.
- Skip: 0001→0010 (bin 1→3) → step=2, multi_bit_err=1 and stays 1 through later legal steps until clr.
- Overflow: ACC_WIDTH=4 instance, 17 single steps → total=1, overflow=1.
- clr on the same cycle as a step → total=0, overflow=0, multi_bit_err=0; step_valid=1, step=1 that cycle.
- en=0 during 3 increments, then en=1 for one more → only one step_valid with step=1, total=1, bin_out tracks throughout.
- Reset asserted mid-run with bin 7: outputs 0 without a clock edge. After release with gray_in held at bin 7, no step_valid; the next increment gives step=1.
